// File: rtl/pixel_unpacker_if.sv
// Packed-video AXI-Stream link carrying 32-bit words of 24-bit RGB pixels.
//   tdata  : packed pixel bytes
//   tkeep  : byte enables, always 4'hF on a well-formed stream
//   tlast  : last word of a line
//   tuser  : first word of a frame
//   tvalid : word valid (source)
//   tready : word accepted when tvalid && tready (sink)
interface pixel_unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/pixel_unpacker.sv
// Unpacks a 32-bit stream of 24-bit RGB pixels (4 pixels per 3 words) into one
// pixel per handshake with x/y coordinates, and checks stream framing against
// the configured geometry with sticky error flags.
//   aclk, aresetn         : clock, async active-low reset
//   in_stream             : packed input stream (slave side)
//   pix_r/g/b             : unpacked pixel
//   pix_x, pix_y          : coordinate of the pixel held in the output slot
//   pix_sof, pix_eol      : slot pixel is (0,0) / last of line
//   pix_valid, pix_ready  : output handshake
//   err_clear             : pulse clearing the sticky flags
//   sof_err/eol_err/keep_err : sticky framing errors
//   frame_count           : completed output frames, wrapping
module pixel_unpacker #(
    parameter int unsigned X_SIZE = 640,
    parameter int unsigned Y_SIZE = 480
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    pixel_unpacker_if.slave        in_stream,
    output logic [7:0]             pix_r,
    output logic [7:0]             pix_g,
    output logic [7:0]             pix_b,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    input  logic                   err_clear,
    output logic                   sof_err,
    output logic                   eol_err,
    output logic                   keep_err,
    output logic [15:0]            frame_count
);

    localparam int unsigned WORDS_PER_LINE = X_SIZE * 3 / 4;
    localparam int unsigned X_W            = 10;
    localparam int unsigned Y_W            = 9;
    localparam int unsigned WCNT_W         = 10;
    localparam int unsigned FC_W           = 16;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    logic [1:0]        phase, phase_nxt;
    logic [23:0]       residue, residue_nxt;
    logic [23:0]       pix_rgb, rgb_nxt;
    logic              emit;
    logic              slot_free;
    logic              accept;
    logic              pix_hs;
    logic [X_W-1:0]    x_nxt;
    logic [Y_W-1:0]    y_nxt;
    logic [FC_W-1:0]   frame_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [Y_W-1:0]    iline, iline_nxt;
    logic              wcnt_last;
    logic              sof_hit, eol_hit, keep_hit;

    // Slot can take a new pixel when empty or being drained this cycle.
    assign slot_free       = !pix_valid || pix_ready;
    assign in_stream.tready = aresetn && (phase != PH3) && slot_free;
    assign accept          = in_stream.tvalid && in_stream.tready;
    assign pix_hs          = pix_valid && pix_ready;

    assign pix_r = pix_rgb[23:16];
    assign pix_g = pix_rgb[15:8];
    assign pix_b = pix_rgb[7:0];

    // Phase FSM next state: each phase splices new bytes onto the residue.
    always_comb begin
        phase_nxt   = phase;
        residue_nxt = residue;
        rgb_nxt     = pix_rgb;
        emit        = 1'b0;
        case (phase)
            PH0: if (accept) begin
                rgb_nxt     = in_stream.tdata[23:0];
                residue_nxt = {16'h0, in_stream.tdata[31:24]};
                emit        = 1'b1;
                phase_nxt   = PH1;
            end
            PH1: if (accept) begin
                rgb_nxt     = {in_stream.tdata[15:0], residue[7:0]};
                residue_nxt = {8'h0, in_stream.tdata[31:16]};
                emit        = 1'b1;
                phase_nxt   = PH2;
            end
            PH2: if (accept) begin
                rgb_nxt     = {in_stream.tdata[7:0], residue[15:0]};
                residue_nxt = in_stream.tdata[31:8];
                emit        = 1'b1;
                phase_nxt   = PH3;
            end
            PH3: if (slot_free) begin
                // Fourth pixel of the group comes entirely from the residue.
                rgb_nxt   = residue;
                emit      = 1'b1;
                phase_nxt = PH0;
            end
            default: phase_nxt = PH0;
        endcase
    end

    // Output coordinates and frame counter advance on pixel handshake.
    always_comb begin
        x_nxt     = pix_x;
        y_nxt     = pix_y;
        frame_nxt = frame_count;
        if (pix_hs) begin
            if (pix_x == X_W'(X_SIZE - 1)) begin
                x_nxt = '0;
                if (pix_y == Y_W'(Y_SIZE - 1)) begin
                    y_nxt     = '0;
                    frame_nxt = frame_count + FC_W'(1);
                end else begin
                    y_nxt = pix_y + Y_W'(1);
                end
            end else begin
                x_nxt = pix_x + X_W'(1);
            end
        end
    end

    // Input-side geometry tracking and framing checks per accepted word.
    assign wcnt_last = (wcnt == WCNT_W'(WORDS_PER_LINE - 1));
    assign eol_hit   = accept && (in_stream.tlast != wcnt_last);
    assign sof_hit   = accept && (in_stream.tuser != ((wcnt == '0) && (iline == '0)));
    assign keep_hit  = accept && (in_stream.tkeep != 4'hF);

    always_comb begin
        wcnt_nxt  = wcnt;
        iline_nxt = iline;
        if (accept) begin
            if (wcnt_last) begin
                wcnt_nxt  = '0;
                iline_nxt = (iline == Y_W'(Y_SIZE - 1)) ? '0 : iline + Y_W'(1);
            end else begin
                wcnt_nxt = wcnt + WCNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase       <= PH0;
            residue     <= '0;
            pix_rgb     <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b1;
            pix_eol     <= 1'b0;
            frame_count <= '0;
            wcnt        <= '0;
            iline       <= '0;
            sof_err     <= 1'b0;
            eol_err     <= 1'b0;
            keep_err    <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            residue     <= residue_nxt;
            pix_rgb     <= rgb_nxt;
            pix_valid   <= emit ? 1'b1 : (pix_ready ? 1'b0 : pix_valid);
            pix_x       <= x_nxt;
            pix_y       <= y_nxt;
            pix_sof     <= (x_nxt == '0) && (y_nxt == '0);
            pix_eol     <= (x_nxt == X_W'(X_SIZE - 1));
            frame_count <= frame_nxt;
            wcnt        <= wcnt_nxt;
            iline       <= iline_nxt;
            // A fresh error outranks a simultaneous clear.
            sof_err     <= sof_hit  || (sof_err  && !err_clear);
            eol_err     <= eol_hit  || (eol_err  && !err_clear);
            keep_err    <= keep_hit || (keep_err && !err_clear);
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
module tb_pixel_unpacker;

    localparam int unsigned X   = 16;
    localparam int unsigned Y   = 3;
    localparam int          WPL = X * 3 / 4;

    typedef struct packed {
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        err_clear = 1'b0;
    logic        sof_err, eol_err, keep_err;
    logic [15:0] frame_count;

    pixel_unpacker_if s_if();

    pixel_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_stream   (s_if),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .err_clear   (err_clear),
        .sof_err     (sof_err),
        .eol_err     (eol_err),
        .keep_err    (keep_err),
        .frame_count (frame_count)
    );

    always #5 aclk = ~aclk;

    int   checks = 0;
    int   errors = 0;
    pix_t q[$];
    int   exp_x = 0;
    int   exp_y = 0;
    int   pcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected pixel with coordinates from the geometry model.
    task automatic push_pix(input logic [23:0] rgb);
        pix_t e;
        e.rgb = rgb;
        e.x   = 10'(exp_x);
        e.y   = 9'(exp_y);
        e.sof = (exp_x == 0) && (exp_y == 0);
        e.eol = (exp_x == X - 1);
        q.push_back(e);
        exp_x++;
        if (exp_x == X) begin
            exp_x = 0;
            exp_y++;
            if (exp_y == Y) exp_y = 0;
        end
    endtask

    function automatic logic [23:0] pix_val(input int k);
        logic [31:0] v;
        v = (32'(k) * 32'h009E3779) ^ 32'h00A5C3F1;
        return v[23:0];
    endfunction

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        while (!done) begin
            @(negedge aclk);
            if (s_if.tready) begin
                @(posedge aclk);
                #1;
                done = 1;
            end else if (++n > 100) begin
                checks++;
                errors++;
                $display("FAIL word_accept_timeout actual=stalled required=accepted");
                done = 1;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    // One line of model pixels; word indices select framing faults.
    task automatic send_line(input int lastw, input bit first, input int userw,
                             input int keepw, input int clrw);
        logic [23:0] p0, p1, p2, p3;
        logic [31:0] w [3];
        int          wi;
        for (int g = 0; g < X / 4; g++) begin
            p0 = pix_val(pcount);
            p1 = pix_val(pcount + 1);
            p2 = pix_val(pcount + 2);
            p3 = pix_val(pcount + 3);
            pcount += 4;
            w[0] = {p1[7:0], p0};
            w[1] = {p2[15:0], p1[23:8]};
            w[2] = {p3, p2[23:16]};
            for (int j = 0; j < 3; j++) begin
                wi = g * 3 + j;
                if (j == 0) push_pix(p0);
                if (j == 1) push_pix(p1);
                if (j == 2) begin
                    push_pix(p2);
                    push_pix(p3);
                end
                if (wi == clrw) err_clear = 1'b1;
                send_word(w[j], (wi == keepw) ? 4'h7 : 4'hF, wi == lastw,
                          (first && wi == 0) || wi == userw);
                err_clear = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        q.delete();
        exp_x = 0;
        exp_y = 0;
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_tready", 32'(s_if.tready), 0);
        chk("rst_xy", {13'h0, pix_x, pix_y}, 0);
        chk("rst_rgb", {8'h0, pix_r, pix_g, pix_b}, 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_errs", {29'h0, sof_err, eol_err, keep_err}, 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_release_tready", 32'(s_if.tready), 1);
    endtask

    task automatic drain();
        repeat (6) @(posedge aclk);
        #1;
        chk("sb_empty", 32'(q.size()), 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
    endtask

    // Scoreboard monitor: compares every output handshake against the queue.
    initial begin
        pix_t a, e;
        forever begin
            @(negedge aclk);
            if (aresetn && pix_valid && pix_ready) begin
                a = '{rgb: {pix_r, pix_g, pix_b}, x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected actual rgb=%h x=%0d y=%0d required=none",
                             a.rgb, a.x, a.y);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL pixel actual rgb=%h x=%0d y=%0d sof=%b eol=%b required rgb=%h x=%0d y=%0d sof=%b eol=%b",
                                 a.rgb, a.x, a.y, a.sof, a.eol, e.rgb, e.x, e.y, e.sof, e.eol);
                    end
                end
            end
        end
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = 4'hF;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;

        do_reset();

        // Hand-packed group.
        push_pix(24'hCCBBAA);
        send_word(32'hDDCCBBAA, 4'hF, 1'b0, 1'b1);
        push_pix(24'h1100DD);
        send_word(32'h33221100, 4'hF, 1'b0, 1'b0);
        push_pix(24'h443322);
        push_pix(24'h776655);
        send_word(32'h77665544, 4'hF, 1'b0, 1'b0);
        chk("ph3_tready", 32'(s_if.tready), 0);
        chk("ph3_pix_valid", 32'(pix_valid), 1);
        drain();
        chk("group_errs", {29'h0, sof_err, eol_err, keep_err}, 0);

        // Mid-group reset: residue from this word must be discarded.
        push_pix(24'hCCBBAA);
        send_word(32'hDDCCBBAA, 4'hF, 1'b0, 1'b1);
        repeat (2) @(posedge aclk);
        do_reset();

        // Backpressure mid-group.
        fork
            begin
                push_pix(24'hCCBBAA);
                send_word(32'hDDCCBBAA, 4'hF, 1'b0, 1'b1);
                push_pix(24'h1100DD);
                send_word(32'h33221100, 4'hF, 1'b0, 1'b0);
                push_pix(24'h443322);
                push_pix(24'h776655);
                send_word(32'h77665544, 4'hF, 1'b0, 1'b0);
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge aclk);
                    n++;
                end while (!pix_valid && n < 50);
                chk("bp_first_valid", 32'(pix_valid), 1);
                @(posedge aclk);
                #1 pix_ready = 1'b0;
                repeat (5) begin
                    @(negedge aclk);
                    chk("bp_valid", 32'(pix_valid), 1);
                    chk("bp_tready", 32'(s_if.tready), 0);
                    chk("bp_hold", {8'h0, pix_r, pix_g, pix_b}, {8'h0, q[0].rgb});
                end
                @(posedge aclk);
                #1 pix_ready = 1'b1;
            end
        join
        drain();

        // Line framing.
        do_reset();
        send_line(WPL - 1, 1'b1, -1, -1, -1);
        drain();
        chk("line_eol_ok", 32'(eol_err), 0);
        send_line(WPL - 2, 1'b0, -1, -1, -1);
        drain();
        chk("line_eol_bad", 32'(eol_err), 1);
        pulse_clear();
        chk("line_eol_cleared", 32'(eol_err), 0);
        send_line(-1, 1'b0, -1, -1, WPL - 1);
        drain();
        chk("line_eol_beats_clear", 32'(eol_err), 1);

        // SOF and keep errors.
        do_reset();
        send_line(WPL - 1, 1'b1, 5, -1, -1);
        drain();
        chk("sof_err_set", 32'(sof_err), 1);
        chk("sof_keep_clean", 32'(keep_err), 0);
        pulse_clear();
        send_line(WPL - 1, 1'b0, -1, 2, -1);
        drain();
        chk("keep_err_set", 32'(keep_err), 1);
        chk("keep_sof_clean", 32'(sof_err), 0);

        // Full frame, then first group of the next frame.
        do_reset();
        for (int l = 0; l < Y; l++) send_line(WPL - 1, l == 0, -1, -1, -1);
        drain();
        chk("frame_count_1", 32'(frame_count), 1);
        chk("frame_errs", {29'h0, sof_err, eol_err, keep_err}, 0);
        send_line(WPL - 1, 1'b1, -1, -1, -1);
        drain();
        chk("frame2_errs", {29'h0, sof_err, eol_err, keep_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Receive-side counterpart of the video pixel packer. Consumes the 32-bit AXI-Stream video produced by the pixel generator (24-bit RGB packed 4 pixels per 3 words, tuser = start of frame, tlast = end of line). Unpacks the stream back into one RGB pixel per handshake with x/y coordinates. Checks stream framing against the configured geometry and raises sticky error flags. Used as the frame checker in the generator testbench and as the front end of on-chip video consumers.

## Interface
- X_SIZE, 640, pixels per line; multiple of 4, ≤ 1024
- Y_SIZE, 480, lines per frame; ≤ 512
- aclk  in  1  single clock for the block
- aresetn  in  1  reset, asynchronous, active-low
- in_stream_tdata  in  32  packed pixel bytes
- in_stream_tkeep  in  4  byte enables; must be 4'hF
- in_stream_tlast  in  1  last word of a line
- in_stream_tuser  in  1  first word of a frame
- in_stream_tvalid  in  1  word valid
- in_stream_tready  out  1  word accepted when tvalid && tready
- pix_r, pix_g, pix_b  out  8 each  unpacked pixel
- pix_x  out  10  column of current output pixel
- pix_y  out  9  row of current output pixel
- pix_sof  out  1  pix_x==0 && pix_y==0
- pix_eol  out  1  pix_x==X_SIZE-1
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready
- err_clear  in  1  single-cycle pulse, clears sticky flags
- sof_err, eol_err, keep_err  out  1 each  sticky framing errors
- frame_count  out  16  completed frames, wraps at 65535

## Operation
- Packing: pixel = {r,g,b} = bits[23:0]; stream byte 0 = pixel bits[7:0]. Group of 4 pixels p0..p3 in words w0..w2: w0 = {p1[7:0], p0}, w1 = {p2[15:0], p1[23:8]}, w2 = {p3, p2[23:16]}.
- Phase FSM (2-bit), residue register (24-bit):
  - PH0: accept word -> emit tdata[23:0]; residue = tdata[31:24]; -> PH1.
  - PH1: accept -> emit {tdata[15:0], residue[7:0]}; residue = tdata[31:16]; -> PH2.
  - PH2: accept -> emit {tdata[7:0], residue[15:0]}; residue = tdata[31:8]; -> PH3.
  - PH3: no input consumed; emit residue[23:0]; -> PH0.
- Output slot: single registered pixel. Slot free = !pix_valid || pix_ready. in_stream_tready = aresetn && phase!=PH3 && slot free (combinational from pix_ready). PH3 emits when slot free.
- Output counters advance on pixel handshake: pix_x wraps X_SIZE-1 -> 0 and increments pix_y; pix_y wraps Y_SIZE-1 -> 0 and increments frame_count.
- Input-side checks use word counter wcnt (0..X_SIZE*3/4-1) and line counter iline (0..Y_SIZE-1), advanced per accepted word:
  - eol_err set when accepted tlast != (wcnt == X_SIZE*3/4-1).
  - sof_err set when accepted tuser != (wcnt==0 && iline==0).
  - keep_err set when accepted tkeep != 4'hF; data still used.
- No resynchronisation on errors: counters and phase follow geometry only; recovery is via aresetn.
- err_clear clears all three flags; an error detected in the same cycle wins (flag stays set).

## Timing
- Reset (async assert): phase PH0, residue 0, pix_valid 0, pix_rgb 0, pix_x 0, pix_y 0, wcnt/iline 0, all errors 0, frame_count 0, in_stream_tready 0. Cycle after release: tready 1.
- Latency: word accepted at edge N -> pix_valid high with its pixel after edge N. PH3 pixel follows at edge N+1 if slot free.
- Throughput: 1 pixel/cycle; tready low one cycle in four at full rate.
- Simultaneous drain and load in one cycle is allowed (no bubble).
- pix_valid, once high, holds data and coordinates stable until pix_ready.
- Reset mid-frame: residue discarded, next accepted word treated as frame start.

## Test plan
- Reset: assert aresetn low mid-stream -> all outputs at reset values; tready 0 during reset, 1 after release.
- Group: w0=0xDDCCBBAA (tuser), w1=0x33221100, w2=0x77665544 -> pixels 0xCCBBAA, 0x1100DD, 0x443322, 0x776655 at x=0..3; tready low in PH3 cycle; no errors.
- Backpressure: hold pix_ready low 5 cycles mid-group -> pix_valid and data stable, tready 0, no pixel lost or duplicated.
- Line: 480 words, tlast on word 479 -> pix_eol on x=639, next pixel x=0 y=1, eol_err 0; repeat with tlast on word 478 -> eol_err 1; err_clear -> 0.
- SOF/keep: tuser on word 5 -> sof_err 1; tkeep=4'h7 on one word -> keep_err 1, pixel data unchanged.
- Frame: 230400 words with correct tuser/tlast -> frame_count 1, pix_sof on next pixel (0,0), no error flags.
